// File: rtl/intc_prio.sv
// intc_prio: parametrised priority interrupt controller with edge/level channels, masking, nested in-service tracking and vector output.
module intc_prio #(
  parameter int NCH = 4,
  parameter int IDW = 2,
  parameter int PCW = 10,
  parameter logic [PCW-1:0] VEC_BASE = 10'h3C0,
  parameter int VEC_STEP = 4,
  parameter logic [NCH-1:0] EDGE_MODE = {NCH{1'b1}}
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [NCH-1:0] ie,
  input  logic           cfg_we,
  input  logic [NCH-1:0] cfg_mask,
  input  logic           ack,
  input  logic           eoi,
  output logic           irq,
  output logic [PCW-1:0] vec,
  output logic [IDW-1:0] int_id,
  output logic [NCH-1:0] pend_o,
  output logic [NCH-1:0] isr_o
);
  logic [NCH-1:0] ie_q, pend_q, pend_d, isr_q, isr_d, mask_q, mask_d, elig, ack_hot, eoi_hot;
  logic           irq_q, irq_d, acc, blocked;
  logic [IDW-1:0] sel, id_q, id_d;
  logic [PCW-1:0] vec_q, vec_d;
  always_comb begin
    acc = irq_q & ack;
    ack_hot = acc ? NCH'(1) << id_q : '0;
    eoi_hot = eoi ? isr_q & (~isr_q + NCH'(1)) : '0;
    blocked = 1'b0;
    elig = '0;
    sel = '0;
    // a channel is eligible only if no in-service bit sits at or above its priority
    for (int i = 0; i < NCH; i++) begin
      blocked = blocked | isr_q[i];
      elig[i] = pend_q[i] & mask_q[i] & ~blocked;
    end
    for (int i = NCH - 1; i >= 0; i--) sel = elig[i] ? IDW'(i) : sel;
    pend_d = (EDGE_MODE & ((pend_q & ~ack_hot) | (ie & ~ie_q))) | (~EDGE_MODE & ie);
    isr_d = (isr_q & ~eoi_hot) | ack_hot;
    mask_d = cfg_we ? cfg_mask : mask_q;
    irq_d = (|elig) & ~acc;
    id_d = irq_d ? sel : id_q;
    vec_d = irq_d ? VEC_BASE + PCW'(sel) * PCW'(VEC_STEP) : vec_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      ie_q <= '0;
      pend_q <= '0;
      isr_q <= '0;
      mask_q <= '0;
      irq_q <= 1'b0;
      id_q <= '0;
      vec_q <= '0;
    end else begin
      ie_q <= ie;
      pend_q <= pend_d;
      isr_q <= isr_d;
      mask_q <= mask_d;
      irq_q <= irq_d;
      id_q <= id_d;
      vec_q <= vec_d;
    end
  end
  assign irq = irq_q;
  assign vec = vec_q;
  assign int_id = id_q;
  assign pend_o = pend_q;
  assign isr_o = isr_q;
endmodule

// File: tb/tb_intc_prio.sv
// tb_intc_prio: vector table, random stimulus against a stack-based reference model, and a level-mode sequence.
module tb_intc_prio;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset, cfg_we, ack, eoi, irq;
  logic [3:0] ie, cfg_mask, pend_o, isr_o;
  logic [9:0] vec;
  logic [1:0] int_id;
  logic reset2, cfg_we2, ack2, eoi2, irq2;
  logic [3:0] ie2, cfg_mask2, pend_o2, isr_o2;
  logic [9:0] vec2;
  logic [1:0] int_id2;
  int total = 0, bad = 0;

  intc_prio dut (.clk(clk), .reset(reset), .ie(ie), .cfg_we(cfg_we), .cfg_mask(cfg_mask),
    .ack(ack), .eoi(eoi), .irq(irq), .vec(vec), .int_id(int_id), .pend_o(pend_o), .isr_o(isr_o));
  intc_prio #(.EDGE_MODE(4'b1110)) dut2 (.clk(clk), .reset(reset2), .ie(ie2), .cfg_we(cfg_we2),
    .cfg_mask(cfg_mask2), .ack(ack2), .eoi(eoi2), .irq(irq2), .vec(vec2), .int_id(int_id2),
    .pend_o(pend_o2), .isr_o(isr_o2));

  bit m_irq;
  int m_id, m_vec;
  bit [3:0] m_pend, m_mask, m_prev;
  int m_isr[$];

  typedef struct {
    bit r; bit [3:0] ie; bit we; bit [3:0] mk; bit ak; bit eo;
    bit e_irq; int e_id; int e_vec; bit [3:0] e_pend; bit [3:0] e_isr;
  } row_t;
  row_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, exp);
    end
  endtask

  function automatic bit [3:0] isr_bits();
    bit [3:0] b = '0;
    foreach (m_isr[k]) b[m_isr[k]] = 1'b1;
    return b;
  endfunction

  task automatic model_step(input bit r, input bit [3:0] i_ie, input bit we, input bit [3:0] mk,
                            input bit ak, input bit eo);
    bit acc;
    int lim, sel;
    if (r) begin
      m_irq = 0; m_id = 0; m_vec = 0; m_pend = 0; m_mask = 0; m_prev = 0;
      m_isr.delete();
    end else begin
      acc = m_irq && ak;
      lim = m_isr.size() > 0 ? m_isr[0] : 4;
      sel = -1;
      for (int i = 0; i < lim; i++) if (sel < 0 && m_pend[i] && m_mask[i]) sel = i;
      for (int i = 0; i < 4; i++)
        m_pend[i] = (m_pend[i] && !(acc && m_id == i)) || (i_ie[i] && !m_prev[i]);
      if (eo && m_isr.size() > 0) void'(m_isr.pop_front());
      if (acc) m_isr.push_front(m_id);
      m_irq = !acc && sel >= 0;
      if (m_irq) begin
        m_id = sel;
        m_vec = (960 + sel * 4) % 1024;
      end
      if (we) m_mask = mk;
      m_prev = i_ie;
    end
  endtask

  task automatic step(input bit r, input bit [3:0] i_ie, input bit we, input bit [3:0] mk,
                      input bit ak, input bit eo);
    reset = r; ie = i_ie; cfg_we = we; cfg_mask = mk; ack = ak; eoi = eo;
    @(posedge clk);
    model_step(r, i_ie, we, mk, ak, eo);
    #1;
    chk("model irq", irq, m_irq);
    chk("model pend", pend_o, m_pend);
    chk("model isr", isr_o, isr_bits());
    if (m_irq) begin
      chk("model id", int_id, m_id);
      chk("model vec", vec, m_vec);
    end
  endtask

  function automatic void add(input bit r, input bit [3:0] i_ie, input bit we, input bit [3:0] mk,
      input bit ak, input bit eo, input bit e_irq, input int e_id, input int e_vec,
      input bit [3:0] e_pend, input bit [3:0] e_isr);
    row_t t;
    t.r = r; t.ie = i_ie; t.we = we; t.mk = mk; t.ak = ak; t.eo = eo;
    t.e_irq = e_irq; t.e_id = e_id; t.e_vec = e_vec; t.e_pend = e_pend; t.e_isr = e_isr;
    tbl.push_back(t);
  endfunction

  task automatic step2(input bit r, input bit [3:0] i_ie, input bit we, input bit ak, input bit eo,
                       input bit e_irq, input bit [3:0] e_pend, input bit [3:0] e_isr);
    reset2 = r; ie2 = i_ie; cfg_we2 = we; cfg_mask2 = 4'hF; ack2 = ak; eoi2 = eo;
    @(posedge clk);
    #1;
    chk("lvl irq", irq2, e_irq);
    chk("lvl pend", pend_o2, e_pend);
    chk("lvl isr", isr_o2, e_isr);
    if (e_irq) begin
      chk("lvl id", int_id2, 0);
      chk("lvl vec", vec2, 10'h3C0);
    end
  endtask

  initial begin
    reset2 = 1; ie2 = 0; cfg_we2 = 0; cfg_mask2 = 0; ack2 = 0; eoi2 = 0;
    //  r  ie  we mk  ak eo | irq id vec     pend isr
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 4'h0);
    add(0, 0, 1, 4'hF, 0, 0, 0, 0, 0, 4'h0, 4'h0);
    add(0, 4'h4, 0, 0, 0, 0, 0, 0, 0, 4'h4, 4'h0);
    add(0, 0, 0, 0, 0, 0, 1, 2, 10'h3C8, 4'h4, 4'h0);
    add(0, 0, 0, 0, 1, 0, 0, 0, 0, 4'h0, 4'h4);
    add(0, 4'h1, 0, 0, 0, 0, 0, 0, 0, 4'h1, 4'h4);
    add(0, 0, 0, 0, 0, 0, 1, 0, 10'h3C0, 4'h1, 4'h4);
    add(0, 0, 0, 0, 1, 0, 0, 0, 0, 4'h0, 4'h5);
    add(0, 0, 0, 0, 0, 1, 0, 0, 0, 4'h0, 4'h4);
    add(0, 0, 0, 0, 0, 1, 0, 0, 0, 4'h0, 4'h0);
    add(0, 0, 0, 0, 0, 1, 0, 0, 0, 4'h0, 4'h0);
    add(0, 4'hA, 0, 0, 0, 0, 0, 0, 0, 4'hA, 4'h0);
    add(0, 0, 0, 0, 0, 0, 1, 1, 10'h3C4, 4'hA, 4'h0);
    add(0, 0, 0, 0, 1, 0, 0, 0, 0, 4'h8, 4'h2);
    add(0, 0, 0, 0, 1, 0, 0, 0, 0, 4'h8, 4'h2);
    add(0, 0, 0, 0, 0, 1, 0, 0, 0, 4'h8, 4'h0);
    add(0, 0, 0, 0, 0, 0, 1, 3, 10'h3CC, 4'h8, 4'h0);
    add(0, 0, 0, 0, 1, 0, 0, 0, 0, 4'h0, 4'h8);
    add(0, 0, 0, 0, 0, 1, 0, 0, 0, 4'h0, 4'h0);
    add(0, 0, 1, 4'hE, 0, 0, 0, 0, 0, 4'h0, 4'h0);
    add(0, 4'h1, 0, 0, 0, 0, 0, 0, 0, 4'h1, 4'h0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h1, 4'h0);
    add(0, 0, 1, 4'hF, 0, 0, 0, 0, 0, 4'h1, 4'h0);
    add(0, 0, 0, 0, 0, 0, 1, 0, 10'h3C0, 4'h1, 4'h0);
    add(0, 0, 0, 0, 1, 0, 0, 0, 0, 4'h0, 4'h1);
    add(0, 0, 0, 0, 0, 1, 0, 0, 0, 4'h0, 4'h0);
    add(0, 4'h2, 0, 0, 0, 0, 0, 0, 0, 4'h2, 4'h0);
    add(0, 0, 0, 0, 0, 0, 1, 1, 10'h3C4, 4'h2, 4'h0);
    add(0, 4'h2, 0, 0, 1, 0, 0, 0, 0, 4'h2, 4'h2);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h2, 4'h2);
    add(0, 0, 0, 0, 0, 1, 0, 0, 0, 4'h2, 4'h0);
    add(0, 0, 0, 0, 0, 0, 1, 1, 10'h3C4, 4'h2, 4'h0);
    add(0, 4'h1, 0, 0, 0, 0, 1, 1, 10'h3C4, 4'h3, 4'h0);
    add(0, 0, 0, 0, 0, 0, 1, 0, 10'h3C0, 4'h3, 4'h0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 4'h0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 4'h0);
    foreach (tbl[n]) begin
      step(tbl[n].r, tbl[n].ie, tbl[n].we, tbl[n].mk, tbl[n].ak, tbl[n].eo);
      chk($sformatf("row%0d irq", n), irq, tbl[n].e_irq);
      chk($sformatf("row%0d pend", n), pend_o, tbl[n].e_pend);
      chk($sformatf("row%0d isr", n), isr_o, tbl[n].e_isr);
      if (tbl[n].e_irq) begin
        chk($sformatf("row%0d id", n), int_id, tbl[n].e_id);
        chk($sformatf("row%0d vec", n), vec, tbl[n].e_vec);
      end
    end
    step(0, 0, 1, 4'hF, 0, 0);
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 59) == 0, 4'($urandom & $urandom), $urandom_range(0, 11) == 0,
           $urandom_range(0, 1) ? 4'hF : 4'($urandom), $urandom_range(0, 2) == 0,
           $urandom_range(0, 4) == 0);
    end
    //     r  ie  we ak eo | irq pend isr
    step2(1, 0, 0, 0, 0, 0, 4'h0, 4'h0);
    step2(0, 4'h1, 1, 0, 0, 0, 4'h1, 4'h0);
    step2(0, 4'h1, 0, 0, 0, 1, 4'h1, 4'h0);
    step2(0, 4'h1, 0, 1, 0, 0, 4'h1, 4'h1);
    step2(0, 4'h1, 0, 0, 0, 0, 4'h1, 4'h1);
    step2(0, 4'h1, 0, 0, 1, 0, 4'h1, 4'h0);
    step2(0, 4'h1, 0, 0, 0, 1, 4'h1, 4'h0);
    step2(0, 4'h0, 0, 0, 0, 1, 4'h0, 4'h0);
    step2(0, 4'h0, 0, 0, 0, 0, 4'h0, 4'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/intc_prio.md
# intc_prio

Parametrised priority interrupt controller between the CPU's external interrupt lines and its fetch logic. Generalises the fixed four-line interrupt inputs to NCH channels, with per-channel edge/level mode, a software-loadable mask, nested in-service tracking and a computed jump vector. The CPU accepts a request with a one-cycle `ack` and retires it with `eoi`.

## Interface
- NCH, 4, number of interrupt channels; channel 0 has the highest priority.
- IDW, 2, channel-id width; must satisfy 2^IDW >= NCH.
- PCW, 10, vector (program-counter) width.
- VEC_BASE, 10'h3C0, vector of channel 0.
- VEC_STEP, 4, vector spacing between consecutive channels.
- EDGE_MODE, all ones (NCH bits), per channel: 1 = rising-edge triggered, 0 = level.

- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- ie  in  NCH  interrupt request lines, synchronous to clk.
- cfg_we  in  1  load mask from cfg_mask.
- cfg_mask  in  NCH  mask value; 1 = channel enabled.
- ack  in  1  CPU accepts the current request.
- eoi  in  1  CPU finished the current handler.
- irq  out  1  request to CPU (registered).
- vec  out  PCW  handler address (registered).
- int_id  out  IDW  selected channel (registered).
- pend_o  out  NCH  pending bits.
- isr_o  out  NCH  in-service bits.

## Operation
- State registers: ie_q, pending, inservice, mask, irq, vec, int_id.
- Reset value of every register and output: 0. Mask = 0, so all channels are disabled.
- ie_q also resets to 0. A line that is already high when reset is released counts as one edge on the first clock.
- Edge channel: `ie & ~ie_q` sets pending[i]. ack on that channel clears it. A new edge in the same cycle as the clearing ack wins, so the bit stays 1.
- Level channel: pending[i] = registered ie[i]. ack does not clear it; the source must deassert the line.
- Masked channels still latch pending but are never eligible.
- Eligibility: pending[i] & mask[i], and i is strictly lower than the lowest set inservice index. With inservice empty, every channel qualifies.
- Selection: the lowest eligible index is sel.
- vec = VEC_BASE + sel*VEC_STEP, computed in PCW bits and wrapping modulo 2^PCW.
- ack accepted (irq=1 and ack=1):
  - pending[int_id] cleared (edge mode only);
  - inservice[int_id] set;
  - irq forced to 0 on the next edge.
- ack while irq=0: ignored.
- eoi clears the lowest set inservice bit. eoi with inservice empty: no effect.
- ack and eoi in the same cycle: eoi acts on the old inservice, ack then sets its bit. Both take effect.
- cfg_we takes effect on the next edge. Unmasking a pending channel raises irq one cycle later.
- A higher-priority request arriving while irq=1 and no ack yet: vec and int_id switch to the new channel on the following edge. irq stays 1.
- Reset mid-handshake: all state is cleared on that edge, including inservice.

## Timing
- ie rises before edge t:
  - pending set after edge t;
  - irq, vec and int_id valid after edge t+1 (2-cycle latency).
- ack sampled at edge a:
  - irq = 0 after edge a;
  - re-evaluated irq valid after edge a+1.
  - Minimum spacing between accepted acks: 2 cycles.
- eoi at edge e: the next eligible request shows on irq after edge e+1.
- vec and int_id are stable whenever irq=1, except for a higher-priority preemption before ack.
- No combinational path from any input to any output.

## Test plan
- Reset, then mask=4'b1111 and a pulse on ie[2] → pend_o=4'b0100 after 1 edge; irq=1, int_id=2, vec=10'h3C8 after 2 edges.
- ie[3] and ie[1] rise on the same cycle → int_id=1, vec=10'h3C4. ack → isr_o=4'b0010 and irq drops for 1 cycle. ch3 is not eligible (nesting) until eoi. After eoi → int_id=3, vec=10'h3CC.
- In service on ch2, ie[0] edge → irq with int_id=0 (nested). A later eoi clears isr bit 0 first, leaving isr_o=4'b0100.
- mask=4'b1110 and an edge on ie[0] → pend_o[0]=1, irq=0. Write mask=4'b1111 → irq=1, int_id=0 one cycle later.
- EDGE_MODE=4'b1110 with ie[0] held high → ack sets isr[0] and pend_o[0] stays 1. After eoi, irq reasserts while the line is still high.
- New edge on ch1 in the same cycle as ack of ch1 → pend_o[1] stays 1. Reset asserted mid-service → all outputs 0 on the next edge.
